// File: rtl/dvfs_pkg.sv
// Shared types and constants for the DVFS transition sequencer.
//   level_t     : 4-bit performance level, same code for freq_sel and vr_code
//   seq_state_t : sequencer state encoding
//   LEVEL_MAX   : highest level code
//   max3()      : helper used to size the shared wait counter
package dvfs_pkg;

    localparam int unsigned LEVEL_W = 4;

    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t LEVEL_MAX = 4'hF;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_V_UP     = 3'd1,
        SEQ_V_SETTLE = 3'd2,
        SEQ_F_SWITCH = 3'd3,
        SEQ_F_LOCK   = 3'd4,
        SEQ_V_DOWN   = 3'd5,
        SEQ_DONE     = 3'd6
    } seq_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dvfs_wait_timer.sv
// Loadable down-counter shared by the settle, lock and regulator-timeout waits.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : value loaded; the count then decrements to 0 and holds
//   expired_o    : registered, high while the count is 0
module dvfs_wait_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         expired_q;

    // Count down to zero and stick there; a load restarts the wait.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == '0);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/dvfs_transition_sequencer.sv
// Orders voltage and frequency changes so the core never runs faster than its
// supply allows: raise = voltage, settle, frequency; lower = frequency, lock
// wait, voltage. Owns the final freq_sel.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid_i/_level_i  : target level offered by AVFS policy / APB override
//   req_ready_o           : idle and able to accept
//   vr_req_o/vr_code_o    : voltage-change request and code to the regulator
//   vr_ack_i              : regulator completion
//   freq_sel_o            : frequency selection to divider/PLL
//   busy_o                : transition in progress
//   done_o                : one-cycle pulse when a transition completes/aborts
//   err_o                 : sticky regulator-timeout flag
// Optional feature: define DVFS_SEQ_TIMEOUT_EN to abort a regulator request
// that is not acknowledged within TIMEOUT_CYCLES; otherwise err_o is tied 0.
module dvfs_transition_sequencer
    import dvfs_pkg::*;
#(
    parameter level_t      RESET_LEVEL    = LEVEL_MAX,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned LOCK_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   req_valid_i,
    input  level_t req_level_i,
    output logic   req_ready_o,
    output logic   vr_req_o,
    output level_t vr_code_o,
    input  logic   vr_ack_i,
    output level_t freq_sel_o,
    output logic   busy_o,
    output logic   done_o,
    output logic   err_o
);

    localparam int unsigned WAIT_MAX    = max3(SETTLE_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W       = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);
    // A wait of N cycles loads N-1 because the exit is taken in the cycle the
    // count reads 0; a zero parameter still yields a one-cycle wait.
    localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
    localparam int unsigned LOCK_LOAD   = (LOCK_CYCLES == 0) ? 0 : LOCK_CYCLES - 1;
`ifdef DVFS_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_LOAD    = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
`endif

    seq_state_t       state_q, state_d;
    level_t           target_q, target_d;
    level_t           freq_sel_q, freq_sel_d;
    level_t           vr_code_q, vr_code_d;
    logic             vr_req_q, vr_req_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
`ifdef DVFS_SEQ_TIMEOUT_EN
    logic             err_q, err_d;
`endif

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;

    dvfs_wait_timer #(
        .W (CNT_W)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        freq_sel_d = freq_sel_q;
        vr_code_d  = vr_code_q;
`ifdef DVFS_SEQ_TIMEOUT_EN
        err_d      = err_q;
`endif
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state_q)
            SEQ_IDLE: begin
                if (req_valid_i) begin
                    target_d = req_level_i;
`ifdef DVFS_SEQ_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    if (req_level_i > freq_sel_q) begin
                        state_d = SEQ_V_UP;
                    end else if (req_level_i < freq_sel_q) begin
                        state_d = SEQ_F_SWITCH;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            SEQ_V_UP: begin
                if (vr_ack_i) begin
                    state_d = SEQ_V_SETTLE;
`ifdef DVFS_SEQ_TIMEOUT_EN
                end else if (tmr_expired) begin
                    // Frequency untouched, so abandoning the raise is safe.
                    state_d = SEQ_DONE;
                    err_d   = 1'b1;
`endif
                end
            end
            SEQ_V_SETTLE: begin
                if (tmr_expired) begin
                    state_d = SEQ_F_SWITCH;
                end
            end
            SEQ_F_SWITCH: begin
                freq_sel_d = target_q;
                // Target above current frequency means voltage is already up.
                state_d    = (target_q > freq_sel_q) ? SEQ_DONE : SEQ_F_LOCK;
            end
            SEQ_F_LOCK: begin
                if (tmr_expired) begin
                    state_d = SEQ_V_DOWN;
                end
            end
            SEQ_V_DOWN: begin
                if (vr_ack_i) begin
                    state_d = SEQ_DONE;
`ifdef DVFS_SEQ_TIMEOUT_EN
                end else if (tmr_expired) begin
                    // Frequency already lowered; staying at higher voltage is safe.
                    state_d = SEQ_DONE;
                    err_d   = 1'b1;
`endif
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        // Wait counter loads on entry to each timed state.
        if (state_d != state_q) begin
            case (state_d)
                SEQ_V_SETTLE: begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(SETTLE_LOAD);
                end
                SEQ_F_LOCK: begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(LOCK_LOAD);
                end
`ifdef DVFS_SEQ_TIMEOUT_EN
                SEQ_V_UP, SEQ_V_DOWN: begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(TMO_LOAD);
                end
`endif
                default: begin
                    tmr_load = 1'b0;
                end
            endcase
        end

        vr_req_d = (state_d == SEQ_V_UP) || (state_d == SEQ_V_DOWN);
        // vr_code only moves on the edge where vr_req rises, so it is stable
        // for the whole request.
        if (vr_req_d && !((state_q == SEQ_V_UP) || (state_q == SEQ_V_DOWN))) begin
            vr_code_d = target_d;
        end
        busy_d  = (state_d != SEQ_IDLE);
        ready_d = (state_d == SEQ_IDLE);
        done_d  = (state_q == SEQ_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEQ_IDLE;
            target_q   <= RESET_LEVEL;
            freq_sel_q <= RESET_LEVEL;
            vr_code_q  <= RESET_LEVEL;
            vr_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            freq_sel_q <= freq_sel_d;
            vr_code_q  <= vr_code_d;
            vr_req_q   <= vr_req_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

`ifdef DVFS_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign req_ready_o = ready_q;
    assign vr_req_o    = vr_req_q;
    assign vr_code_o   = vr_code_q;
    assign freq_sel_o  = freq_sel_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
